// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serialiser, RX deserialiser with one
// holding register, W1C status flags and a level interrupt.
module uart_periph #(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bAddr,
   input  logic [31:0] bWData,
   input  logic        bSel,
   input  logic        bWrite,
   input  logic [1:0]  mem_size,
   output logic [31:0] bRData,
   output logic        txd,
   input  logic        rxd,
   output logic        irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [15:0]   baud_reg;
   logic [3:0]    ctrl_reg;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;

   state_t        tx_state_reg;
   logic [15:0]   tx_cnt_reg;
   logic [2:0]    tx_bit_reg;
   logic [7:0]    tx_shift_reg;
   logic          txd_reg;

   state_t        rx_state_reg;
   logic [15:0]   rx_cnt_reg;
   logic [2:0]    rx_bit_reg;
   logic [7:0]    rx_shift_reg;
   logic [7:0]    rx_data_reg;
   logic          rx_valid_reg, rx_overrun_reg, rx_frame_err_reg;
   logic [1:0]    rx_sync_reg;
   logic          rx_prev_reg;

   logic wr_access, word_wr, data_wr, status_wr, baud_wr, ctrl_wr;
   logic tx_full, tx_empty, tx_busy, push, tx_pop, rx_s;
   logic [15:0] half_load;
   logic unused_bits;

   assign wr_access = bSel & bWrite;
   assign word_wr   = wr_access & (mem_size == 2'b10);
   assign data_wr   = wr_access & (bAddr[3:2] == 2'd0);
   assign status_wr = word_wr & (bAddr[3:2] == 2'd1);
   assign baud_wr   = word_wr & (bAddr[3:2] == 2'd2);
   assign ctrl_wr   = word_wr & (bAddr[3:2] == 2'd3);

   assign tx_full  = (count_reg == CW'(FIFO_DEPTH));
   assign tx_empty = (count_reg == '0);
   assign tx_busy  = (tx_state_reg != S_IDLE);
   assign push     = data_wr & ~tx_full;
   // A pop happens either from IDLE or at the end of STOP for gapless back-to-back frames.
   assign tx_pop   = ctrl_reg[0] & ~tx_empty &
                     ((tx_state_reg == S_IDLE) | ((tx_state_reg == S_STOP) & (tx_cnt_reg == 16'd0)));
   assign rx_s     = rx_sync_reg[1];
   assign half_load = (baud_reg == 16'd0) ? 16'd0 :
                      16'(({1'b0, baud_reg} + 17'd1) >> 1) - 16'd1;
   assign unused_bits = ^{bAddr[31:4], bAddr[1:0], bWData[31:16]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baud_reg <= DEFAULT_DIV;
         ctrl_reg <= 4'd0;
      end else begin
         if (baud_wr) baud_reg <= bWData[15:0];
         if (ctrl_wr) ctrl_reg <= bWData[3:0];
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= bWData[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (tx_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, tx_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // txd is registered from the current state, so the line lags the FSM by one clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_reg <= S_IDLE;
         tx_cnt_reg   <= 16'd0;
         tx_bit_reg   <= 3'd0;
         tx_shift_reg <= 8'd0;
         txd_reg      <= 1'b1;
      end else begin
         txd_reg <= (tx_state_reg == S_START) ? 1'b0 :
                    (tx_state_reg == S_DATA)  ? tx_shift_reg[0] : 1'b1;
         case (tx_state_reg)
            S_IDLE: if (tx_pop) begin
               tx_shift_reg <= fifo_mem[rd_ptr_reg];
               tx_cnt_reg   <= baud_reg;
               tx_state_reg <= S_START;
            end
            S_START: if (tx_cnt_reg == 16'd0) begin
               tx_cnt_reg   <= baud_reg;
               tx_bit_reg   <= 3'd0;
               tx_state_reg <= S_DATA;
            end else tx_cnt_reg <= tx_cnt_reg - 16'd1;
            S_DATA: if (tx_cnt_reg == 16'd0) begin
               tx_cnt_reg   <= baud_reg;
               tx_shift_reg <= tx_shift_reg >> 1;
               tx_bit_reg   <= tx_bit_reg + 3'd1;
               if (tx_bit_reg == 3'd7) tx_state_reg <= S_STOP;
            end else tx_cnt_reg <= tx_cnt_reg - 16'd1;
            default: if (tx_cnt_reg == 16'd0) begin
               if (tx_pop) begin
                  tx_shift_reg <= fifo_mem[rd_ptr_reg];
                  tx_cnt_reg   <= baud_reg;
                  tx_state_reg <= S_START;
               end else tx_state_reg <= S_IDLE;
            end else tx_cnt_reg <= tx_cnt_reg - 16'd1;
         endcase
      end
   end

   // W1C is applied first so that a hardware set later in the block wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_sync_reg      <= 2'b11;
         rx_prev_reg      <= 1'b1;
         rx_state_reg     <= S_IDLE;
         rx_cnt_reg       <= 16'd0;
         rx_bit_reg       <= 3'd0;
         rx_shift_reg     <= 8'd0;
         rx_data_reg      <= 8'd0;
         rx_valid_reg     <= 1'b0;
         rx_overrun_reg   <= 1'b0;
         rx_frame_err_reg <= 1'b0;
      end else begin
         rx_sync_reg <= {rx_sync_reg[0], rxd};
         rx_prev_reg <= rx_s;
         if (status_wr) begin
            rx_valid_reg     <= rx_valid_reg & ~bWData[3];
            rx_overrun_reg   <= rx_overrun_reg & ~bWData[4];
            rx_frame_err_reg <= rx_frame_err_reg & ~bWData[5];
         end
         if (!ctrl_reg[1]) rx_state_reg <= S_IDLE;
         else begin
            case (rx_state_reg)
               S_IDLE: if (rx_prev_reg & ~rx_s) begin
                  rx_cnt_reg   <= half_load;
                  rx_state_reg <= S_START;
               end
               S_START: if (rx_cnt_reg == 16'd0) begin
                  if (rx_s) rx_state_reg <= S_IDLE;
                  else begin
                     rx_cnt_reg   <= baud_reg;
                     rx_bit_reg   <= 3'd0;
                     rx_state_reg <= S_DATA;
                  end
               end else rx_cnt_reg <= rx_cnt_reg - 16'd1;
               S_DATA: if (rx_cnt_reg == 16'd0) begin
                  rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
                  rx_cnt_reg   <= baud_reg;
                  rx_bit_reg   <= rx_bit_reg + 3'd1;
                  if (rx_bit_reg == 3'd7) rx_state_reg <= S_STOP;
               end else rx_cnt_reg <= rx_cnt_reg - 16'd1;
               default: if (rx_cnt_reg == 16'd0) begin
                  rx_state_reg <= S_IDLE;
                  if (rx_s) begin
                     rx_data_reg  <= rx_shift_reg;
                     rx_valid_reg <= 1'b1;
                     if (rx_valid_reg) rx_overrun_reg <= 1'b1;
                  end else rx_frame_err_reg <= 1'b1;
               end else rx_cnt_reg <= rx_cnt_reg - 16'd1;
            endcase
         end
      end
   end

   always_comb begin
      bRData = 32'd0;
      case (bAddr[3:2])
         2'd0:    bRData = {24'd0, rx_data_reg};
         2'd1:    bRData = {26'd0, rx_frame_err_reg, rx_overrun_reg, rx_valid_reg,
                            tx_busy, tx_empty, tx_full};
         2'd2:    bRData = {16'd0, baud_reg};
         default: bRData = {28'd0, ctrl_reg};
      endcase
   end

   assign txd = txd_reg;
   assign irq = (ctrl_reg[2] & rx_valid_reg) | (ctrl_reg[3] & tx_empty & ~tx_busy);
endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph: register vector table, TX/RX frame sequences,
// randomized traffic against a frame-level reference model.
module tb_uart_periph;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] bAddr = 32'd0;
   logic [31:0] bWData = 32'd0;
   logic        bSel = 1'b0;
   logic        bWrite = 1'b0;
   logic [1:0]  mem_size = 2'b10;
   logic [31:0] bRData;
   logic        txd;
   logic        rxd = 1'b1;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [7:0] tx_q[$];

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [1:0]  sz;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;
   vec_t vecs[12];

   always #5 clk = ~clk;

   uart_periph #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd433)) dut (
      .clk(clk), .rst(rst), .bAddr(bAddr), .bWData(bWData), .bSel(bSel),
      .bWrite(bWrite), .mem_size(mem_size), .bRData(bRData), .txd(txd),
      .rxd(rxd), .irq(irq)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [1:0] sz);
      bAddr = {28'd0, a, 2'b00}; bWData = d; mem_size = sz; bSel = 1'b1; bWrite = 1'b1;
      @(negedge clk);
      bSel = 1'b0; bWrite = 1'b0;
      $display("wr reg%0d data=0x%08h size=%0d", a, d, sz);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bAddr = {28'd0, a, 2'b00}; bSel = 1'b1; bWrite = 1'b0;
      #1 d = bRData;
      bSel = 1'b0;
   endtask

   task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(a, v);
      check(name, v, exp);
   endtask

   // Expected line: 1 lead idle sample, then each queued byte as start/8 data/stop bits.
   task automatic expect_tx(input int baud);
      logic [9:0] frame;
      int n;
      n = tx_q.size();
      @(negedge clk);
      check("tx_lead", {31'd0, txd}, 32'd1);
      for (int f = 0; f < n; f++) begin
         frame = {1'b1, tx_q[f], 1'b0};
         for (int b = 0; b < 10; b++)
            for (int c = 0; c <= baud; c++) begin
               @(negedge clk);
               check($sformatf("txd_f%0d_b%0d", f, b), {31'd0, txd}, {31'd0, frame[b]});
            end
         $display("tx frame 0x%02h checked", tx_q[f]);
      end
      check_reg("tx_done_status", 2'd1, 32'h02);
      repeat (3) begin
         @(negedge clk);
         check("tx_idle", {31'd0, txd}, 32'd1);
      end
      tx_q.delete();
   endtask

   task automatic rx_send(input logic [7:0] d, input logic stop_bit, input int baud);
      logic [9:0] frame;
      frame = {stop_bit, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         rxd = frame[b];
         repeat (baud + 1) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (baud + 1) @(negedge clk);
      $display("rx frame 0x%02h stop=%0d sent", d, stop_bit);
   endtask

   initial begin
      logic [31:0] w;
      logic [7:0]  d;
      logic        stop_bit;
      logic        m_valid, m_over, m_ferr;
      logic [7:0]  m_data;
      int          baud, n, sz;

      vecs[0]  = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0,   1'b0};
      vecs[1]  = '{1'b0, 2'd1, 32'h0,        2'd2, 32'h02,  1'b0};
      vecs[2]  = '{1'b0, 2'd2, 32'h0,        2'd2, 32'h1B1, 1'b0};
      vecs[3]  = '{1'b0, 2'd3, 32'h0,        2'd2, 32'h0,   1'b0};
      vecs[4]  = '{1'b1, 2'd2, 32'hFFFF0007, 2'd2, 32'h7,   1'b0};
      vecs[5]  = '{1'b1, 2'd2, 32'h00000055, 2'd0, 32'h7,   1'b0};
      vecs[6]  = '{1'b1, 2'd2, 32'h00000099, 2'd1, 32'h7,   1'b0};
      vecs[7]  = '{1'b1, 2'd3, 32'hFFFFFFF8, 2'd2, 32'h8,   1'b1};
      vecs[8]  = '{1'b1, 2'd3, 32'h00000001, 2'd0, 32'h8,   1'b1};
      vecs[9]  = '{1'b1, 2'd1, 32'h0000003F, 2'd2, 32'h02,  1'b1};
      vecs[10] = '{1'b1, 2'd3, 32'h00000000, 2'd2, 32'h0,   1'b0};
      vecs[11] = '{1'b1, 2'd2, 32'h00000003, 2'd2, 32'h3,   1'b0};

      repeat (3) @(negedge clk);
      check("reset_txd", {31'd0, txd}, 32'd1);
      check("reset_irq", {31'd0, irq}, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].sz);
         else @(negedge clk);
         check_reg($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
         check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      end

      // Single 0x55 frame at BAUD=3.
      bus_write(2'd3, 32'h1, 2'd2);
      tx_q.push_back(8'h55);
      bus_write(2'd0, 32'h55, 2'd0);
      expect_tx(3);

      // Overfill the FIFO with tx disabled, then release it.
      bus_write(2'd3, 32'h0, 2'd2);
      for (int i = 1; i <= 5; i++) begin
         bus_write(2'd0, i, 2'd0);
         if (i == 3) check_reg("fifo_partial", 2'd1, 32'h00);
         if (i >= 4) check_reg($sformatf("fifo_full_%0d", i), 2'd1, 32'h01);
      end
      for (int i = 1; i <= 4; i++) tx_q.push_back(8'(i));
      bus_write(2'd3, 32'h1, 2'd2);
      expect_tx(3);

      // Randomized TX bursts.
      for (int r = 0; r < 3; r++) begin
         baud = int'($urandom_range(1, 5));
         n = int'($urandom_range(1, 4));
         bus_write(2'd3, 32'h0, 2'd2);
         bus_write(2'd2, baud, 2'd2);
         for (int i = 0; i < n; i++) begin
            w = $urandom();
            sz = int'($urandom_range(0, 2));
            tx_q.push_back(w[7:0]);
            bus_write(2'd0, w, 2'(sz));
         end
         bus_write(2'd3, 32'h1, 2'd2);
         expect_tx(baud);
      end

      // RX directed: valid, overrun, W1C, glitch, frame error.
      bus_write(2'd3, 32'h0, 2'd2);
      bus_write(2'd2, 32'd7, 2'd2);
      bus_write(2'd3, 32'h2, 2'd2);
      rx_send(8'hA3, 1'b1, 7);
      check_reg("rx1_status", 2'd1, 32'h0A);
      check_reg("rx1_data", 2'd0, 32'hA3);
      rx_send(8'h5C, 1'b1, 7);
      check_reg("rx2_status", 2'd1, 32'h1A);
      check_reg("rx2_data", 2'd0, 32'h5C);
      bus_write(2'd1, 32'h18, 2'd2);
      check_reg("rx_w1c_status", 2'd1, 32'h02);
      rxd = 1'b0;
      repeat (2) @(negedge clk);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      check_reg("rx_glitch_status", 2'd1, 32'h02);
      rx_send(8'h77, 1'b0, 7);
      check_reg("rx_ferr_status", 2'd1, 32'h22);
      check_reg("rx_ferr_data", 2'd0, 32'h5C);
      bus_write(2'd1, 32'h20, 2'd2);
      check_reg("rx_ferr_clr", 2'd1, 32'h02);

      // Randomized RX traffic against a flag-level model.
      m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0; m_data = 8'h5C;
      for (int r = 0; r < 6; r++) begin
         baud = int'($urandom_range(3, 9));
         bus_write(2'd2, baud, 2'd2);
         w = $urandom();
         d = w[7:0];
         stop_bit = ($urandom_range(0, 4) != 0);
         rx_send(d, stop_bit, baud);
         if (stop_bit) begin
            if (m_valid) m_over = 1'b1;
            m_valid = 1'b1;
            m_data = d;
         end else m_ferr = 1'b1;
         check_reg($sformatf("rnd%0d_status", r), 2'd1, {26'd0, m_ferr, m_over, m_valid, 3'b010});
         check_reg($sformatf("rnd%0d_data", r), 2'd0, {24'd0, m_data});
         w = $urandom();
         sz = int'($urandom_range(0, 2));
         bus_write(2'd1, w, 2'(sz));
         if (sz == 2) begin
            if (w[3]) m_valid = 1'b0;
            if (w[4]) m_over = 1'b0;
            if (w[5]) m_ferr = 1'b0;
         end
         check_reg($sformatf("rnd%0d_w1c", r), 2'd1, {26'd0, m_ferr, m_over, m_valid, 3'b010});
      end

      // Interrupt on receive, cleared by W1C; byte write to CTRL ignored.
      bus_write(2'd1, 32'h38, 2'd2);
      bus_write(2'd2, 32'd7, 2'd2);
      bus_write(2'd3, 32'h6, 2'd2);
      check("irq_before_rx", {31'd0, irq}, 32'd0);
      rx_send(8'h3C, 1'b1, 7);
      check("irq_after_rx", {31'd0, irq}, 32'd1);
      bus_write(2'd1, 32'h08, 2'd2);
      check("irq_after_w1c", {31'd0, irq}, 32'd0);
      bus_write(2'd3, 32'h0, 2'd0);
      check_reg("ctrl_byte_ignored", 2'd3, 32'h6);

      // Asynchronous reset during a TX data bit.
      bus_write(2'd2, 32'd3, 2'd2);
      bus_write(2'd3, 32'h1, 2'd2);
      bus_write(2'd0, 32'h00, 2'd2);
      repeat (9) @(negedge clk);
      check("tx_mid_data", {31'd0, txd}, 32'd0);
      #1 rst = 1'b0;
      #1 check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check_reg("rst_status", 2'd1, 32'h02);
      check_reg("rst_baud", 2'd2, 32'h1B1);
      check_reg("rst_data", 2'd0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_txd", {31'd0, txd}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
